// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared FSM encoding, bus widths and access-error check for the data-memory responder
package dmem_responder_pkg;
    localparam int BE_W   = 4;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int depth);
        return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(depth));
    endfunction
endpackage

// File: rtl/sram_1rw_be.sv
// sram_1rw_be: single-port word array with per-byte write enables and a registered read that clears on writes
module sram_1rw_be import dmem_responder_pkg::*; #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           we,
    input  logic [BE_W-1:0]                be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [WORD_W-1:0]              wdata,
    output logic [WORD_W-1:0]              rdata
);
    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk) begin
        if (en && we)
            for (int i = 0; i < BE_W; i++)
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else if (en) rdata <= we ? '0 : mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory slave with configurable wait states, byte-enabled stores and error flag
module dmem_responder import dmem_responder_pkg::*; #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
    state_t state, state_n;
    logic [3:0] cnt;
    logic cap_we, fire, acc, acc_we, acc_err, in_idle;
    logic [WORD_W-1:0] cap_addr, cap_wdata, acc_addr, acc_wdata;
    logic [BE_W-1:0] cap_be, acc_be;
    // With zero wait states the access happens on the acceptance edge, so it uses the live request fields
    always_comb begin
        in_idle   = state == IDLE;
        fire      = in_idle && req_valid;
        acc       = WAIT_CYCLES == 0 ? fire : (state == WAIT && cnt == 4'd0);
        acc_we    = in_idle ? req_we    : cap_we;
        acc_addr  = in_idle ? req_addr  : cap_addr;
        acc_wdata = in_idle ? req_wdata : cap_wdata;
        acc_be    = in_idle ? req_be    : cap_be;
        acc_err   = addr_err(acc_addr, DEPTH_WORDS);
        state_n   = state;
        case (state)
            IDLE:    state_n = fire ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE;
            WAIT:    state_n = cnt == 4'd0 ? RESP : WAIT;
            RESP:    state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    assign req_ready = in_idle && rst_n;
    assign rsp_valid = state == RESP;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_err   <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
        end else begin
            state <= state_n;
            if (fire) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
                cnt       <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (acc) rsp_err <= acc_err;
        end
    end
    // An errored access is issued as an empty store so the array is untouched and read data clears to zero
    sram_1rw_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (acc),
        .we    (acc_we || acc_err),
        .be    ((acc_we && !acc_err) ? acc_be : '0),
        .addr  (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .rdata (rsp_rdata)
    );
endmodule
